// File: rtl/rs_reg_pkg.sv
// Shared opcode and state encodings for the round-robin register arbiter.
package rs_reg_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SET   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

endpackage

// File: rtl/dff_rs_bank.sv
// WIDTH-bit register with synchronous clear/set/load (clr_n > set_n > ld)
// and asynchronous active-low reset to zero.
module dff_rs_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_n,
    input  logic             set_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (!clr_n) begin
            q_d = '0;
        end else if (!set_n) begin
            q_d = {WIDTH{1'b1}};
        end else if (ld) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rs_reg_arbiter.sv
// Two-client round-robin arbiter owning a shared set/reset register bank.
// Each service runs grant -> capture -> execute, then acks the winner.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | pick a winner from req & ~ack (round-robin on a tie)
//   GNT     | winner granted; capture its op/data or abort if withdrawn
//   EXEC    | apply captured command to the bank, pulse ack, drop grant
module rs_reg_arbiter
    import rs_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] d0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       grant,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ack_q, ack_d;
    logic             rr_last_q, rr_last_d;
    logic             win_q, win_d;
    logic [1:0]       cmd_op_q, cmd_op_d;
    logic [WIDTH-1:0] cmd_d_q, cmd_d_d;

    logic [1:0]       elig;
    logic             bank_clr_n;
    logic             bank_set_n;
    logic             bank_ld;

    // A client acked this cycle sits out one arbitration round.
    assign elig = req & ~ack_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = 2'b00;
        rr_last_d  = rr_last_q;
        win_d      = win_q;
        cmd_op_d   = cmd_op_q;
        cmd_d_d    = cmd_d_q;
        bank_clr_n = 1'b1;
        bank_set_n = 1'b1;
        bank_ld    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    win_d     = (elig == 2'b11) ? ~rr_last_q : elig[1];
                    grant_d   = win_d ? 2'b10 : 2'b01;
                    rr_last_d = win_d;
                    state_d   = ST_GNT;
                end
            end
            ST_GNT: begin
                if (!req[win_q]) begin
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else begin
                    cmd_op_d = win_q ? op1 : op0;
                    cmd_d_d  = win_q ? d1 : d0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cmd_op_q)
                    OP_LOAD:  bank_ld    = 1'b1;
                    OP_CLEAR: bank_clr_n = 1'b0;
                    OP_SET:   bank_set_n = 1'b0;
                    default:  bank_ld    = 1'b0;
                endcase
                grant_d = 2'b00;
                ack_d   = win_q ? 2'b10 : 2'b01;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // rr_last resets to 1 so client 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            ack_q     <= 2'b00;
            rr_last_q <= 1'b1;
            win_q     <= 1'b0;
            cmd_op_q  <= OP_NOP;
            cmd_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            rr_last_q <= rr_last_d;
            win_q     <= win_d;
            cmd_op_q  <= cmd_op_d;
            cmd_d_q   <= cmd_d_d;
        end
    end

    dff_rs_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_n   (bank_clr_n),
        .set_n   (bank_set_n),
        .ld      (bank_ld),
        .d       (cmd_d_q),
        .q       (q)
    );

    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs_reg_arbiter.sv
// Bench for rs_reg_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rs_reg_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] op0 = 2'b00;
    logic [1:0] op1 = 2'b00;
    logic [3:0] d0 = 4'h0;
    logic [3:0] d1 = 4'h0;
    logic [1:0] grant;
    logic [1:0] ack;
    logic       busy;
    logic [3:0] q;

    int n_cmp = 0;
    int n_bad = 0;

    rs_reg_arbiter #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .op0     (op0),
        .d0      (d0),
        .op1     (op1),
        .d1      (d1),
        .grant   (grant),
        .ack     (ack),
        .busy    (busy),
        .q       (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a service is owned by one client and goes
    // "granted, not yet captured" -> "captured" -> done (register written).
    logic [3:0] m_q = 4'h0;
    logic [1:0] m_grant = 2'b00;
    logic [1:0] m_ack = 2'b00;
    logic       m_busy = 1'b0;
    logic       m_last = 1'b1;
    int         m_owner = -1;
    bit         m_captured = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [3:0] m_d = 4'h0;
    logic [1:0] m_prev_ack;
    logic [1:0] m_elig;
    int         m_w;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_q = 4'h0; m_grant = 2'b00; m_ack = 2'b00; m_busy = 1'b0;
            m_last = 1'b1; m_owner = -1; m_captured = 1'b0;
        end else begin
            m_prev_ack = m_ack;
            m_ack = 2'b00;
            if (m_owner < 0) begin
                m_elig = req & ~m_prev_ack;
                if (m_elig == 2'b11) m_w = m_last ? 0 : 1;
                else if (m_elig == 2'b01) m_w = 0;
                else if (m_elig == 2'b10) m_w = 1;
                else m_w = -1;
                if (m_w >= 0) begin
                    m_owner = m_w;
                    m_captured = 1'b0;
                    m_last = (m_w == 1);
                    m_grant = (m_w == 1) ? 2'b10 : 2'b01;
                end
            end else if (!m_captured) begin
                if (!req[m_owner]) begin
                    m_owner = -1;
                    m_grant = 2'b00;
                end else begin
                    m_captured = 1'b1;
                    m_op = (m_owner == 1) ? op1 : op0;
                    m_d  = (m_owner == 1) ? d1 : d0;
                end
            end else begin
                if (m_op == 2'b01) m_q = m_d;
                else if (m_op == 2'b10) m_q = 4'h0;
                else if (m_op == 2'b11) m_q = 4'hF;
                m_ack = (m_owner == 1) ? 2'b10 : 2'b01;
                m_grant = 2'b00;
                m_owner = -1;
            end
            m_busy = (m_owner >= 0);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_grant", {6'd0, grant}, {6'd0, m_grant});
        chk("model_ack",   {6'd0, ack},   {6'd0, m_ack});
        chk("model_busy",  {7'd0, busy},  {7'd0, m_busy});
        chk("model_q",     {4'd0, q},     {4'd0, m_q});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack == 2'b00 && n < 12) begin
            tick();
            n++;
        end
        if (ack == 2'b00) chk({name, "_timeout"}, 8'd0, 8'd1);
    endtask

    task automatic serve(input string name, input int c, input logic [1:0] op,
                         input logic [3:0] d, input logic [3:0] exp_q);
        @(negedge clk);
        if (c == 1) begin req = 2'b10; op1 = op; d1 = d; end
        else        begin req = 2'b01; op0 = op; d0 = d; end
        tick();
        wait_ack(name);
        chk({name, "_ack"}, {6'd0, ack}, (c == 1) ? 8'h02 : 8'h01);
        chk({name, "_q"}, {4'd0, q}, {4'd0, exp_q});
        @(negedge clk);
        req = 2'b00;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // single load, cycle by cycle
        req = 2'b01; op0 = 2'b01; d0 = 4'hA;
        tick();
        chk("e0_grant", {6'd0, grant}, 8'h01);
        chk("e0_busy", {7'd0, busy}, 8'h01);
        tick();
        chk("e1_q", {4'd0, q}, 8'h00);
        tick();
        chk("e2_q", {4'd0, q}, 8'h0A);
        chk("e2_ack", {6'd0, ack}, 8'h01);
        chk("e2_busy", {7'd0, busy}, 8'h00);
        chk("e2_grant", {6'd0, grant}, 8'h00);
        @(negedge clk);
        req = 2'b00;
        tick();
        chk("e3_ack", {6'd0, ack}, 8'h00);

        serve("set1",   1, 2'b11, 4'h0, 4'hF);
        serve("clear0", 0, 2'b10, 4'h9, 4'h0);
        serve("load0",  0, 2'b01, 4'h5, 4'h5);
        serve("nop1",   1, 2'b00, 4'h3, 4'h5);

        // contention: last served was client 1, so client 0 goes first
        @(negedge clk);
        req = 2'b11; op0 = 2'b01; d0 = 4'h3; op1 = 2'b01; d1 = 4'hC;
        for (int i = 0; i < 4; i++) begin
            tick();
            wait_ack("cont");
            chk("cont_ack", {6'd0, ack}, (i % 2 == 1) ? 8'h02 : 8'h01);
            chk("cont_q", {4'd0, q}, (i % 2 == 1) ? 8'h0C : 8'h03);
        end
        @(negedge clk);
        req = 2'b00;
        repeat (3) tick();

        // abort: client 0 withdraws during GNT, waiting client 1 follows
        @(negedge clk);
        req = 2'b01; op0 = 2'b01; d0 = 4'h9;
        tick();
        chk("abort_e0_grant", {6'd0, grant}, 8'h01);
        @(negedge clk);
        req = 2'b10; op1 = 2'b01; d1 = 4'h6;
        tick();
        chk("abort_grant", {6'd0, grant}, 8'h00);
        chk("abort_ack", {6'd0, ack}, 8'h00);
        chk("abort_q", {4'd0, q}, 8'h0C);
        tick();
        chk("abort_next_grant", {6'd0, grant}, 8'h02);
        tick();
        tick();
        chk("abort_next_ack", {6'd0, ack}, 8'h02);
        chk("abort_next_q", {4'd0, q}, 8'h06);
        @(negedge clk);
        req = 2'b00;
        repeat (2) tick();

        // reset during EXEC of LOAD 0111
        @(negedge clk);
        req = 2'b01; op0 = 2'b01; d0 = 4'h7;
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_q", {4'd0, q}, 8'h00);
        chk("rst_grant", {6'd0, grant}, 8'h00);
        chk("rst_ack", {6'd0, ack}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req = 2'b11; op1 = 2'b01; d1 = 4'hD;
        tick();
        chk("post_rst_grant", {6'd0, grant}, 8'h01);
        wait_ack("post_rst");
        chk("post_rst_ack", {6'd0, ack}, 8'h01);
        chk("post_rst_q", {4'd0, q}, 8'h07);

        // random traffic with occasional resets, model checks every cycle
        repeat (400) begin
            @(negedge clk);
            req = 2'($urandom);
            op0 = 2'($urandom);
            op1 = 2'($urandom);
            d0 = 4'($urandom);
            d1 = 4'($urandom);
            reset_n = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        req = 2'b00;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
